// File: rtl/dma_apb_regfile.sv
// APB3 register file for the 4-channel DMA controller: per-channel SRC/DST/CNT/CTRL,
// global DONE status with write-1-to-clear, interrupt generation and channel retirement.
module dma_apb_regfile #(
  parameter int PADDR_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [PADDR_W-1:0] PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic [127:0]       src_addr_flat,
  output logic [127:0]       dest_addr_flat,
  output logic [127:0]       count_flat,
  output logic [3:0]         ch_req,
  input  logic [3:0]         transfer_done,
  output logic               irq
);

  localparam logic [31:0] ID_VALUE = 32'h444D_4104;

  logic [3:0][31:0] srcQ, srcD;
  logic [3:0][31:0] dstQ, dstD;
  logic [3:0][31:0] cntQ, cntD;
  logic [3:0]       busyQ, busyD;
  logic [3:0]       ieQ, ieD;
  logic [3:0]       doneQ, doneD;

  logic       upperZero;
  logic       access, wrEn, rdEn;
  logic [1:0] chIdx, regIdx;
  logic       aligned, isChan, isGlob, isStatus, isIrqStat, isId, mapped;
  logic       chBusy, chCntZero;
  logic       lockedWr, startRej, roWr;
  logic [3:0] doneSet, doneClr;

  // Any address bit above the 7-bit decoded window makes the access unmapped.
  if (PADDR_W > 7) begin : gUpper
    assign upperZero = (PADDR[PADDR_W-1:7] == '0);
  end else begin : gNoUpper
    assign upperZero = 1'b1;
  end

  assign access    = PSEL & PENABLE;
  assign wrEn      = access & PWRITE;
  assign rdEn      = access & ~PWRITE;
  assign chIdx     = PADDR[5:4];
  assign regIdx    = PADDR[3:2];
  assign aligned   = (PADDR[1:0] == 2'b00);
  assign isChan    = upperZero & aligned & ~PADDR[6];
  assign isGlob    = upperZero & aligned & PADDR[6] & (PADDR[5:4] == 2'b00);
  assign isStatus  = isGlob & (regIdx == 2'd0);
  assign isIrqStat = isGlob & (regIdx == 2'd1);
  assign isId      = isGlob & (regIdx == 2'd2);
  assign mapped    = isChan | isStatus | isIrqStat | isId;

  assign chBusy    = busyQ[chIdx];
  assign chCntZero = (cntQ[chIdx] == 32'd0);

  // Writes to SRC/DST/CNT are locked while the master may still sample them.
  assign lockedWr  = wrEn & isChan & (regIdx != 2'd3) & chBusy;
  assign startRej  = wrEn & isChan & (regIdx == 2'd3) & PWDATA[0] & (chBusy | chCntZero);
  assign roWr      = wrEn & (isIrqStat | isId);

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~mapped | lockedWr | startRej | roWr);

  assign src_addr_flat  = srcQ;
  assign dest_addr_flat = dstQ;
  assign count_flat     = cntQ;
  assign ch_req         = busyQ;
  assign irq            = |(doneQ & ieQ);

  // Read data mux: driven only during a read access phase, zero otherwise.
  always_comb begin
    PRDATA = 32'd0;
    if (rdEn) begin
      if (isChan) begin
        case (regIdx)
          2'd0:    PRDATA = srcQ[chIdx];
          2'd1:    PRDATA = dstQ[chIdx];
          2'd2:    PRDATA = cntQ[chIdx];
          default: PRDATA = {30'd0, ieQ[chIdx], busyQ[chIdx]};
        endcase
      end else if (isStatus) begin
        PRDATA = {28'd0, doneQ};
      end else if (isIrqStat) begin
        PRDATA = {28'd0, doneQ & ieQ};
      end else if (isId) begin
        PRDATA = ID_VALUE;
      end
    end
  end

  // Next-state: retire finished channels first, then apply the APB write against pre-edge BUSY.
  always_comb begin
    srcD    = srcQ;
    dstD    = dstQ;
    cntD    = cntQ;
    ieD     = ieQ;
    doneSet = transfer_done & busyQ;
    doneClr = (wrEn & isStatus) ? PWDATA[3:0] : 4'd0;
    busyD   = busyQ & ~doneSet;
    doneD   = (doneQ & ~doneClr) | doneSet;
    if (wrEn & isChan) begin
      case (regIdx)
        2'd0: if (!chBusy) srcD[chIdx] = {PWDATA[31:2], 2'b00};
        2'd1: if (!chBusy) dstD[chIdx] = {PWDATA[31:2], 2'b00};
        2'd2: if (!chBusy) cntD[chIdx] = PWDATA;
        default: begin
          ieD[chIdx] = PWDATA[1];
          if (PWDATA[0] && !chBusy && !chCntZero) busyD[chIdx] = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      srcQ  <= '0;
      dstQ  <= '0;
      cntQ  <= '0;
      busyQ <= '0;
      ieQ   <= '0;
      doneQ <= '0;
    end else begin
      srcQ  <= srcD;
      dstQ  <= dstD;
      cntQ  <= cntD;
      busyQ <= busyD;
      ieQ   <= ieD;
      doneQ <= doneD;
    end
  end

endmodule

// File: doc/dma_apb_regfile.md
# dma_apb_regfile

APB3 slave register file that holds the per-channel configuration of the 4-channel DMA controller. It is programmed by the CPU over APB and produces the flattened source, destination and count buses and the per-channel request vector for the arbiter. It consumes the `transfer_done` pulses from the AHB master to retire channels, latch done status and raise the interrupt.

## Interface
- `PADDR_W`, default 8: APB address width. Only `PADDR[6:0]` is decoded; upper bits must be 0, otherwise the access is unmapped.
- `clk` input 1: single clock; APB and DMA side share it.
- `rstn` input 1: asynchronous active-low reset.
- `PSEL`, `PENABLE`, `PWRITE` input 1 each: APB3 control.
- `PADDR` input PADDR_W: byte address.
- `PWDATA` input 32: write data.
- `PRDATA` output 32: read data.
- `PREADY` output 1: tied 1 (zero wait states).
- `PSLVERR` output 1: error response, valid in the access phase.
- `src_addr_flat` output 128: channel n in bits [32n+31:32n].
- `dest_addr_flat` output 128: same packing as `src_addr_flat`.
- `count_flat` output 128: word counts, same packing.
- `ch_req` output 4: per-channel request to the arbiter; equals the BUSY bits.
- `transfer_done` input 4: one-cycle completion pulse per channel from the AHB master.
- `irq` output 1: level interrupt.

## Operation
- Access phase is `PSEL & PENABLE`. Writes commit on the clk edge of the access phase. No state changes in the setup phase.
- Register map, per channel n (0..3), base n*0x10:
  - +0x0 SRC: bits [1:0] are stored as 0.
  - +0x4 DST: bits [1:0] are stored as 0.
  - +0x8 CNT: 32-bit word count.
  - +0xC CTRL: bit0 START (write) / BUSY (read), bit1 IE (read/write). Other bits read 0.
- Global registers:
  - 0x40 STATUS: bits [3:0] DONE, write-1-to-clear.
  - 0x44 IRQ_STAT: bits [3:0] = DONE & IE, read-only.
  - 0x48 ID: reads 0x444D_4104, read-only.
- A write to SRC/DST/CNT while that channel is BUSY is ignored and returns PSLVERR=1. The register is locked because the master samples it at grant.
- CTRL write with START=1:
  - Channel idle and CNT≠0: BUSY←1.
  - Channel already BUSY, or CNT==0: BUSY unchanged and PSLVERR=1.
  - IE is updated by every CTRL write in all cases.
- `transfer_done[n]` with BUSY[n]=1: BUSY[n]←0 and DONE[n]←1.
- `transfer_done[n]` with BUSY[n]=0: ignored.
- `transfer_done` pulses on several channels in the same cycle are all honoured.
- `irq` = |(DONE & IE), driven from registers with no combinational path from APB inputs.
- PSLVERR=1 on:
  - access to an unmapped address (including 0x4C–0x7F), where reads return 0 and writes have no effect;
  - any write to IRQ_STAT or ID;
  - the locked-write and rejected-START cases above.
- PRDATA is combinational from the registers during a read access phase and is 0 otherwise.

## Timing
- Reset: all SRC/DST/CNT/CTRL/DONE = 0, so all flat buses = 0, `ch_req`=0, `irq`=0, PRDATA=0, PSLVERR=0. PREADY=1 at all times.
- START write accepted at edge k: `ch_req[n]`=1 from cycle k+1 and stays high until the edge that samples `transfer_done[n]`=1; it is low the following cycle.
- DONE[n] and `irq` rise in the cycle after `transfer_done[n]`.
- Simultaneous `transfer_done[n]` and a W1C of DONE[n] in the same cycle: set wins, so DONE[n]=1.
- Simultaneous `transfer_done[n]` and a START write to channel n: the done is processed first (BUSY→0) and the START is rejected with PSLVERR=1. Software retries.
- Flat outputs change only on accepted writes; they are stable throughout BUSY.
- Reset asserted mid-transfer: everything clears immediately (asynchronously); late `transfer_done` pulses are then ignored because BUSY=0.

## Test plan
- Reset, then read every register → SRC/DST/CNT/CTRL/STATUS=0, ID=0x444D_4104, `ch_req`=0, `irq`=0, PSLVERR=0.
- Write ch2 SRC=0x1000_0003, DST=0x2000_0000, CNT=5, CTRL=0x3 → `src_addr_flat[95:64]`=0x1000_0000, `count_flat[95:64]`=5, `ch_req`=4'b0100 the cycle after the CTRL write.
- With ch2 BUSY: write CNT=9 → PSLVERR=1 and CNT stays 5. Pulse `transfer_done`=4'b0100 → `ch_req`=0, STATUS=0x4, `irq`=1. Write STATUS=0x4 → `irq`=0.
- Write ch0 CTRL=0x1 with CNT=0 → PSLVERR=1, `ch_req[0]`=0. Read 0x4C → PRDATA=0, PSLVERR=1.
- Ch1 BUSY with IE=1, DONE[1] already 1: in the same cycle pulse `transfer_done[1]` and write STATUS=0x2 → DONE[1]=1, `irq` stays 1.
- Start ch0 and ch3, pulse `transfer_done`=4'b1001 in one cycle → both BUSY clear and STATUS=0x9. Pulse `transfer_done[1]` on an idle ch1 → no change.
